// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the ALU shift path: op codes, legality check,
// direction helper and a width-generic bit-reverse.
package alu_shift_pkg;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t OP_SLL = 3'b000;
  localparam shift_op_t OP_SRL = 3'b001;
  localparam shift_op_t OP_SRA = 3'b010;
  localparam shift_op_t OP_ROL = 3'b011;
  localparam shift_op_t OP_ROR = 3'b101;

  // Widest operand the bit-reverse helper can handle.
  localparam int MAX_W = 256;

  function automatic logic is_legal_op(input shift_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Ops that are computed on the mirrored operand.
  function automatic logic is_right_op(input shift_op_t op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  // Reverses the low w bits of d into the low w bits of the result.
  // The operand is first moved to the top so a full-width mirror lands it
  // at the bottom; callers truncate the result back to w bits.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d,
                                                   input int w);
    logic [MAX_W-1:0] t;
    logic [MAX_W-1:0] r;
    t = d << (MAX_W - w);
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = t[MAX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One log2 step of the barrel shifter: optional left shift by 2^K,
// filling from the wrapped bits (rotate) or from a supplied fill bit.
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             fill,
  input  logic             rotate,
  output logic [WIDTH-1:0] result
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;

  // Build the shifted word, then pick it only when this amount bit is set
  always_comb begin
    if (rotate) begin
      shifted = {data[WIDTH-S-1:0], data[WIDTH-1:WIDTH-S]};
    end else begin
      shifted = {data[WIDTH-S-1:0], {S{fill}}};
    end
    result = enable ? shifted : data;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter for the ALU shift path. Stages run MSB-first;
// a register follows every REG_EVERY stages and the final stage. Each
// register slot has its own valid bit, and a slot accepts whenever it is
// empty or its contents move on, so bubbles collapse under back-pressure.
module pipelined_barrel_shifter
  import alu_shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  shift_op_t                in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int L       = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

  // Pipeline registers; index i is the register after group i.
  logic [WIDTH-1:0]   data_reg [L];
  logic [SHAMT_W-1:0] amt_reg  [L];
  shift_op_t          op_reg   [L];
  logic [TAG_W-1:0]   tag_reg  [L];
  logic [L-1:0]       fill_reg;
  logic [L-1:0]       err_reg;
  logic [L-1:0]       valid_reg;

  // Values presented to each register by its group of stages.
  logic [WIDTH-1:0]   nxt_data [L];
  logic [SHAMT_W-1:0] nxt_amt  [L];
  shift_op_t          nxt_op   [L];
  logic [TAG_W-1:0]   nxt_tag  [L];
  logic [L-1:0]       nxt_fill;
  logic [L-1:0]       nxt_err;
  logic [L-1:0]       nxt_valid;

  logic [L:0] adv;

  // Ready chain from the consumer back to the source, one slot at a time
  always_comb begin
    adv    = '0;
    adv[L] = out_ready;
    for (int i = L - 1; i >= 0; i--) begin
      adv[i] = !valid_reg[i] || adv[i+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar gi = 0; gi < L; gi++) begin : g_grp
    localparam int TOP_K = SHAMT_W - 1 - gi * REG_EVERY;
    localparam int N     = (REG_EVERY < TOP_K + 1) ? REG_EVERY : TOP_K + 1;

    logic [WIDTH-1:0]   grp_data;
    logic [SHAMT_W-1:0] grp_amt;
    shift_op_t          grp_op;
    logic [TAG_W-1:0]   grp_tag;
    logic               grp_fill;
    logic               grp_err;
    logic               grp_rotate;
    logic [WIDTH-1:0]   chain [N+1];

    if (gi == 0) begin : g_src
      // Right-direction ops run through the left shifter on the mirrored operand;
      // SRA's sign bit is captured here and travels with the transaction.
      assign grp_data      = is_right_op(in_op) ? WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH)) : in_data;
      assign grp_amt       = in_amt;
      assign grp_op        = in_op;
      assign grp_tag       = in_tag;
      assign grp_fill      = (in_op == OP_SRA) & in_data[WIDTH-1];
      assign grp_err       = !is_legal_op(in_op);
      assign nxt_valid[gi] = in_valid;
    end else begin : g_src
      assign grp_data      = data_reg[gi-1];
      assign grp_amt       = amt_reg[gi-1];
      assign grp_op        = op_reg[gi-1];
      assign grp_tag       = tag_reg[gi-1];
      assign grp_fill      = fill_reg[gi-1];
      assign grp_err       = err_reg[gi-1];
      assign nxt_valid[gi] = valid_reg[gi-1];
    end

    assign grp_rotate = (grp_op == OP_ROL) || (grp_op == OP_ROR);
    assign chain[0]   = grp_data;

    for (genvar si = 0; si < N; si++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .K     (TOP_K - si)
      ) u_stage (
        .data   (chain[si]),
        .enable (grp_amt[TOP_K-si]),
        .fill   (grp_fill),
        .rotate (grp_rotate),
        .result (chain[si+1])
      );
    end

    if (gi == L - 1) begin : g_out
      // Un-mirror right-direction results and force illegal ops to zero
      assign nxt_data[gi] = grp_err ? '0 :
                            (is_right_op(grp_op) ? WIDTH'(bit_reverse(MAX_W'(chain[N]), WIDTH)) : chain[N]);
    end else begin : g_mid
      assign nxt_data[gi] = chain[N];
    end

    assign nxt_amt[gi]  = grp_amt;
    assign nxt_op[gi]   = grp_op;
    assign nxt_tag[gi]  = grp_tag;
    assign nxt_fill[gi] = grp_fill;
    assign nxt_err[gi]  = grp_err;
  end

  // Load each slot when it advances; payload only changes for a real transaction
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      fill_reg  <= '0;
      err_reg   <= '0;
      for (int i = 0; i < L; i++) begin
        data_reg[i] <= '0;
        amt_reg[i]  <= '0;
        op_reg[i]   <= OP_SLL;
        tag_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < L; i++) begin
        if (adv[i]) begin
          valid_reg[i] <= nxt_valid[i];
          if (nxt_valid[i]) begin
            data_reg[i] <= nxt_data[i];
            amt_reg[i]  <= nxt_amt[i];
            op_reg[i]   <= nxt_op[i];
            tag_reg[i]  <= nxt_tag[i];
            fill_reg[i] <= nxt_fill[i];
            err_reg[i]  <= nxt_err[i];
          end
        end
      end
    end
  end

  assign out_valid = valid_reg[L-1];
  assign out_data  = data_reg[L-1];
  assign out_tag   = tag_reg[L-1];
  assign out_err   = err_reg[L-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vectors on the 32-bit/L=3 instance plus
// random sweeps on 8-bit (L=3) and 64-bit (L=1) instances, all scored
// through expected-result queues.
module tb_pipelined_barrel_shifter;
  import alu_shift_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic [4:0]  in_tag, out_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t        main_q[$];
  exp_t        main_e;
  logic [63:0] cur_exp;
  logic        cur_err;
  logic        sweep_go = 1'b0;

  pipelined_barrel_shifter #(
    .WIDTH     (32),
    .REG_EVERY (2),
    .TAG_W     (5)
  ) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, obs, exp);
    end
  endtask

  // Reference model written directly in shift/or form.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a,
                                            input logic [2:0] op, input int w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case (op)
      3'b000: r = (d << a) & mask;
      3'b001: r = d >> a;
      3'b010: begin
        r = d >> a;
        if (d[w-1]) r = r | (mask & ~(mask >> a));
      end
      3'b011: r = (a == 0) ? d : (((d << a) | (d >> (w - a))) & mask);
      3'b101: r = (a == 0) ? d : (((d >> a) | (d << (w - a))) & mask);
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Main scoreboard: push on accepted input, pop and compare on delivered output
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        $display("main tag=%0d data=%h err=%0b", out_tag, out_data, out_err);
        check_eq("main_sb_nonempty", 64'(main_q.size() != 0), 64'd1);
        if (main_q.size() != 0) begin
          main_e = main_q.pop_front();
          check_eq("main_data", 64'(out_data), main_e.data);
          check_eq("main_tag", 64'(out_tag), 64'(main_e.tag));
          check_eq("main_err", 64'(out_err), 64'(main_e.err));
        end
      end
      if (in_valid && in_ready) begin
        main_q.push_back('{data: cur_exp, tag: 8'(in_tag), err: cur_err});
      end
    end
  end

  // In-flight transactions are discarded by reset
  always @(negedge reset_n) main_q.delete();

  task automatic send(input logic [31:0] d, input int a, input logic [2:0] op,
                      input int tag, input logic [63:0] exp, input logic err);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = 5'(a);
    in_op    = op;
    in_tag   = 5'(tag);
    cur_exp  = exp;
    cur_err  = err;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) check_eq("send_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  // Called right after a lone transaction is accepted on an empty pipeline
  task automatic lat_check();
    @(negedge clock);
    check_eq("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clock);
    check_eq("lat_edge2", 64'(out_valid), 64'd0);
    @(negedge clock);
    check_eq("lat_edge3", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && main_q.size() != 0; c++) @(negedge clock);
    check_eq("main_drain", 64'(main_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Random sweeps on two other parameter points
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int W  = (gi == 0) ? 8 : 64;
    localparam int RE = (gi == 0) ? 1 : 6;
    localparam int SW = $clog2(W);

    logic          sw_in_valid, sw_in_ready, sw_out_valid, sw_out_ready, sw_out_err;
    logic [W-1:0]  sw_in_data, sw_out_data;
    logic [SW-1:0] sw_in_amt;
    logic [2:0]    sw_in_op;
    logic [4:0]    sw_in_tag, sw_out_tag;
    logic [63:0]   pend_exp;
    logic          pend_err;
    logic          sw_done = 1'b0;
    exp_t          q[$];
    exp_t          e;

    pipelined_barrel_shifter #(
      .WIDTH     (W),
      .REG_EVERY (RE),
      .TAG_W     (5)
    ) u_sweep (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready),
      .in_data   (sw_in_data),
      .in_amt    (sw_in_amt),
      .in_op     (sw_in_op),
      .in_tag    (sw_in_tag),
      .out_valid (sw_out_valid),
      .out_ready (sw_out_ready),
      .out_data  (sw_out_data),
      .out_tag   (sw_out_tag),
      .out_err   (sw_out_err)
    );

    // Sweep scoreboard
    always @(negedge clock) begin
      if (reset_n) begin
        if (sw_out_valid && sw_out_ready) begin
          $display("w%0d tag=%0d data=%h err=%0b", W, sw_out_tag, sw_out_data, sw_out_err);
          check_eq($sformatf("w%0d_sb_nonempty", W), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check_eq($sformatf("w%0d_data", W), 64'(sw_out_data), e.data);
            check_eq($sformatf("w%0d_tag", W), 64'(sw_out_tag), 64'(e.tag));
            check_eq($sformatf("w%0d_err", W), 64'(sw_out_err), 64'(e.err));
          end
        end
        if (sw_in_valid && sw_in_ready) begin
          q.push_back('{data: pend_exp, tag: 8'(sw_in_tag), err: pend_err});
        end
      end
    end

    initial begin
      sw_in_valid  = 1'b0;
      sw_out_ready = 1'b0;
      sw_in_data   = '0;
      sw_in_amt    = '0;
      sw_in_op     = 3'b000;
      sw_in_tag    = '0;
      pend_exp     = '0;
      pend_err     = 1'b0;
      wait (sweep_go);
      @(posedge clock);
      #1;
      fork
        begin
          while (!sw_done) begin
            sw_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
          end
        end
        begin
          int  n;
          logic acc;
          n = 0;
          while (n < 10000) begin
            if (!sw_in_valid && $urandom_range(0, 3) != 0) begin
              sw_in_data  = W'({$urandom(), $urandom()});
              sw_in_amt   = SW'($urandom_range(0, W - 1));
              sw_in_op    = 3'($urandom_range(0, 7));
              sw_in_tag   = 5'($urandom());
              pend_exp    = ref_shift(64'(sw_in_data), int'(sw_in_amt), sw_in_op, W);
              pend_err    = !(sw_in_op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101});
              sw_in_valid = 1'b1;
            end
            @(negedge clock);
            acc = sw_in_valid && sw_in_ready;
            @(posedge clock);
            #1;
            if (acc) begin
              n++;
              sw_in_valid = 1'b0;
            end
          end
          sw_in_valid = 1'b0;
          for (int c = 0; c < 200 && q.size() != 0; c++) @(negedge clock);
          check_eq($sformatf("w%0d_drain", W), 64'(q.size()), 64'd0);
          sw_done = 1'b1;
        end
      join
    end
  end

  logic [2:0] ops [5];

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = 3'b000;
    in_tag    = '0;
    out_ready = 1'b1;
    cur_exp   = '0;
    cur_err   = 1'b0;
    ops       = '{OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};

    // Reset state
    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_out_err", 64'(out_err), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // SLL by the largest amount, with exact latency
    send(32'h0000_0001, 31, OP_SLL, 1, 64'h8000_0000, 1'b0);
    lat_check();
    drain();

    // Right shifts and rotates, back to back
    send(32'h8000_0000, 4, OP_SRL, 2, 64'h0800_0000, 1'b0);
    send(32'h8000_0000, 4, OP_SRA, 3, 64'hF800_0000, 1'b0);
    send(32'h8000_0001, 1, OP_ROL, 4, 64'h0000_0003, 1'b0);
    send(32'h0000_00F1, 4, OP_ROR, 5, 64'h1000_000F, 1'b0);
    drain();

    // Zero amount is identity for every legal op
    for (int i = 0; i < 5; i++) send(32'hDEAD_BEEF, 0, ops[i], 16 + i, 64'hDEAD_BEEF, 1'b0);
    drain();

    // Illegal op between two legal neighbours
    send(32'h0000_00FF, 8, OP_SLL, 8, 64'h0000_FF00, 1'b0);
    send(32'h1234_5678, 3, 3'b111, 9, 64'h0, 1'b1);
    send(32'hF000_0000, 8, OP_SRA, 10, 64'hFFF0_0000, 1'b0);
    drain();

    // Stream of 8 with a 4-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i + 1), 1, OP_SLL, i, 64'((i + 1) * 2), 1'b0);
      end
      begin
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clock);
          check_eq("stall_valid", 64'(out_valid), 64'd1);
          check_eq("stall_tag", 64'(out_tag), 64'd1);
          check_eq("stall_data", 64'(out_data), 64'd4);
          check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three transactions in flight
    send(32'h0000_000A, 1, OP_SLL, 11, 64'h14, 1'b0);
    send(32'h0000_000B, 1, OP_SLL, 12, 64'h16, 1'b0);
    send(32'h0000_000C, 1, OP_SLL, 13, 64'h18, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_out_data", 64'(out_data), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    #4 reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check_eq("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clock);
    #1;
    send(32'h0000_0003, 2, OP_SLL, 14, 64'h0000_000C, 1'b0);
    lat_check();
    drain();

    // Parameter sweeps
    sweep_go = 1'b1;
    for (int c = 0; c < 80000 && !(g_sweep[0].sw_done && g_sweep[1].sw_done); c++) @(posedge clock);
    check_eq("sweep_done", 64'({g_sweep[0].sw_done, g_sweep[1].sw_done}), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
